// File: rtl/cpu_stats_pkg.sv
// Shared definitions for the CPU run-control and statistics unit.
package cpu_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Largest 8-digit decimal value the display can show.
  localparam int unsigned CNT_MAX_DEFAULT = 99_999_999;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q < MAX)) begin
      q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_stats.sv
// Run-control FSM, statistics counters and syscall-34 LED latch for the CPU.
//   state   | meaning
//   IDLE    | waiting for a start edge after reset or clear
//   RUN     | CPU enabled, counters live
//   HALT    | syscall-10 seen, counters frozen until the next start edge
module cpu_stats
  import cpu_stats_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             halt_req,
  input  logic             uncondi_retire,
  input  logic             condi_taken,
  input  logic             led_req,
  input  logic [31:0]      led_req_data,
  output logic             cpu_run,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] total_cycles,
  output logic [WIDTH-1:0] uncondi_branch_num,
  output logic [WIDTH-1:0] condi_branch_num,
  output logic [31:0]      led_data_out,
  output logic             led_cpu_enable
);

  state_e      state_q, state_d;
  logic        start_q;
  logic [31:0] led_data_q, led_data_d;
  logic        led_en_q, led_en_d;
  logic        start_rise;
  logic        in_run;

  assign start_rise = start & ~start_q;
  assign in_run     = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    led_data_d = led_data_q;
    led_en_d   = 1'b0;
    if (clear) begin
      state_d    = ST_IDLE;
      led_data_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_rise) state_d = ST_RUN;
        ST_RUN:  if (halt_req)   state_d = ST_HALT;
        ST_HALT: if (start_rise) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
      if (in_run && led_req) begin
        led_data_d = led_req_data;
        led_en_d   = 1'b1;
      end
    end
  end

  // start_q resets high so a button held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b1;
      led_data_q <= '0;
      led_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      led_data_q <= led_data_d;
      led_en_q   <= led_en_d;
    end
  end

  sat_counter #(.WIDTH(WIDTH), .MAX(WIDTH'(CNT_MAX))) u_total (
    .clk (clk), .rst (rst), .clr (clear),
    .en  (in_run),
    .q   (total_cycles)
  );

  sat_counter #(.WIDTH(WIDTH), .MAX(WIDTH'(CNT_MAX))) u_uncondi (
    .clk (clk), .rst (rst), .clr (clear),
    .en  (in_run & uncondi_retire),
    .q   (uncondi_branch_num)
  );

  sat_counter #(.WIDTH(WIDTH), .MAX(WIDTH'(CNT_MAX))) u_condi (
    .clk (clk), .rst (rst), .clr (clear),
    .en  (in_run & condi_taken),
    .q   (condi_branch_num)
  );

  assign cpu_run        = in_run;
  assign state          = state_q;
  assign led_data_out   = led_data_q;
  assign led_cpu_enable = led_en_q;

endmodule

// File: tb/tb_cpu_stats.sv
// Directed bench for cpu_stats; a second instance with a small ceiling exercises saturation.
module tb_cpu_stats;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        halt_req;
  logic        uncondi_retire;
  logic        condi_taken;
  logic        led_req;
  logic [31:0] led_req_data;

  logic        cpu_run;
  logic [1:0]  state;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_branch_num;
  logic [31:0] condi_branch_num;
  logic [31:0] led_data_out;
  logic        led_cpu_enable;

  logic        s_cpu_run;
  logic [1:0]  s_state;
  logic [31:0] s_total;
  logic [31:0] s_uncondi;
  logic [31:0] s_condi;
  logic [31:0] s_led_data;
  logic        s_led_en;

  int checks = 0;
  int errors = 0;

  cpu_stats dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt_req(halt_req),
    .uncondi_retire(uncondi_retire), .condi_taken(condi_taken),
    .led_req(led_req), .led_req_data(led_req_data),
    .cpu_run(cpu_run), .state(state), .total_cycles(total_cycles),
    .uncondi_branch_num(uncondi_branch_num), .condi_branch_num(condi_branch_num),
    .led_data_out(led_data_out), .led_cpu_enable(led_cpu_enable)
  );

  // Ceiling of 11 so that reaching CNT_MAX-1 (10) takes only ten RUN cycles.
  cpu_stats #(.WIDTH(32), .CNT_MAX(11)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .halt_req(halt_req),
    .uncondi_retire(uncondi_retire), .condi_taken(condi_taken),
    .led_req(led_req), .led_req_data(led_req_data),
    .cpu_run(s_cpu_run), .state(s_state), .total_cycles(s_total),
    .uncondi_branch_num(s_uncondi), .condi_branch_num(s_condi),
    .led_data_out(s_led_data), .led_cpu_enable(s_led_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; clear = 1'b0; halt_req = 1'b0;
    uncondi_retire = 1'b0; condi_taken = 1'b0; led_req = 1'b0; led_req_data = '0;
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_total", total_cycles, 32'd0);
    chk("rst_uncondi", uncondi_branch_num, 32'd0);
    chk("rst_condi", condi_branch_num, 32'd0);
    chk("rst_led_data", led_data_out, 32'd0);
    chk("rst_led_en", 32'(led_cpu_enable), 32'd0);

    // start held through reset release: no edge
    rst = 1'b0;
    step(); step();
    chk("held_start_idle", 32'(state), 32'd0);
    chk("held_start_run0", 32'(cpu_run), 32'd0);

    start = 1'b0; step();
    start = 1'b1; step();
    chk("start_to_run", 32'(state), 32'd1);
    chk("start_cpu_run", 32'(cpu_run), 32'd1);
    chk("run_total0", total_cycles, 32'd0);

    for (int i = 0; i < 10; i++) step();
    chk("total_10", total_cycles, 32'd10);
    chk("sat_total_10", s_total, 32'd10);

    // branch events: u=1,1,1,0,0,0  c=1,1,0,1,1,1
    uncondi_retire = 1'b1; condi_taken = 1'b1; step(); step();
    condi_taken = 1'b0; step();
    uncondi_retire = 1'b0; condi_taken = 1'b1; step(); step(); step();
    condi_taken = 1'b0;
    chk("uncondi_3", uncondi_branch_num, 32'd3);
    chk("condi_5", condi_branch_num, 32'd5);
    chk("total_16", total_cycles, 32'd16);
    chk("sat_total_hold11", s_total, 32'd11);
    chk("sat_uncondi_3", s_uncondi, 32'd3);

    halt_req = 1'b1; step();
    halt_req = 1'b0;
    chk("halt_state", 32'(state), 32'd2);
    chk("halt_cpu_run", 32'(cpu_run), 32'd0);
    chk("halt_total_17", total_cycles, 32'd17);

    // events in HALT are ignored
    uncondi_retire = 1'b1; condi_taken = 1'b1; led_req = 1'b1; led_req_data = 32'h55;
    step(); step(); step();
    uncondi_retire = 1'b0; condi_taken = 1'b0; led_req = 1'b0;
    chk("halt_uncondi_hold", uncondi_branch_num, 32'd3);
    chk("halt_condi_hold", condi_branch_num, 32'd5);
    chk("halt_total_hold", total_cycles, 32'd17);
    chk("halt_led_ignored", led_data_out, 32'd0);
    chk("halt_led_en0", 32'(led_cpu_enable), 32'd0);
    chk("sat_total_still11", s_total, 32'd11);

    start = 1'b0; step();
    start = 1'b1; step();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_total", total_cycles, 32'd17);
    chk("resume_uncondi", uncondi_branch_num, 32'd3);

    // halt + start_rise + condi_taken together in RUN
    start = 1'b0; step();
    start = 1'b1; halt_req = 1'b1; condi_taken = 1'b1; step();
    halt_req = 1'b0; condi_taken = 1'b0;
    chk("halt_wins_state", 32'(state), 32'd2);
    chk("halt_condi_6", condi_branch_num, 32'd6);
    chk("halt_total_19", total_cycles, 32'd19);

    start = 1'b0; step();
    start = 1'b1; step();
    chk("resume2_state", 32'(state), 32'd1);
    chk("resume2_condi", condi_branch_num, 32'd6);
    chk("resume2_total", total_cycles, 32'd19);

    led_req = 1'b1; led_req_data = 32'h0000_1234; step();
    chk("led_1234", led_data_out, 32'h0000_1234);
    chk("led_en_1", 32'(led_cpu_enable), 32'd1);
    led_req_data = 32'hDEAD_BEEF; step();
    led_req = 1'b0; led_req_data = 32'h0;
    chk("led_deadbeef", led_data_out, 32'hDEAD_BEEF);
    chk("led_en_2", 32'(led_cpu_enable), 32'd1);
    step();
    chk("led_en_off", 32'(led_cpu_enable), 32'd0);
    chk("led_held", led_data_out, 32'hDEAD_BEEF);
    step();
    chk("led_held2", led_data_out, 32'hDEAD_BEEF);
    chk("total_23", total_cycles, 32'd23);

    clear = 1'b1; step();
    clear = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_cpu_run", 32'(cpu_run), 32'd0);
    chk("clr_total", total_cycles, 32'd0);
    chk("clr_uncondi", uncondi_branch_num, 32'd0);
    chk("clr_condi", condi_branch_num, 32'd0);
    chk("clr_led", led_data_out, 32'd0);
    chk("clr_sat_total", s_total, 32'd0);

    start = 1'b0; step();
    start = 1'b1; step();
    step(); step();
    chk("pre_rst_run", 32'(cpu_run), 32'd1);
    chk("pre_rst_total", total_cycles, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_cpu_run", 32'(cpu_run), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_total", total_cycles, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
